// File: rtl/mips_mc_datapath.sv
// Multicycle MIPS datapath: PC, register file, IR/MDR/A/B/ALUOut, ALU, ALU-control decode and muxes.
// All sequencing lives in the external controller; this block only reacts to the controls present at each edge.
module mips_mc_datapath #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PCWriteCond,
    input  logic             PCWrite,
    input  logic             IorD,
    input  logic             MemtoReg,
    input  logic             IRWrite,
    input  logic             RegWrite,
    input  logic             RegDst,
    input  logic             ALUSrcA,
    input  logic [1:0]       PCSource,
    input  logic [1:0]       ALUSrcB,
    input  logic [1:0]       ALUOp,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [5:0]       opcode,
    output logic             zero,
    output logic [WIDTH-1:0] dbg_pc
);

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_NOP
    } alu_fn_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] mdr_q, mdr_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] aluout_q, aluout_d;
    logic [WIDTH-1:0] rf_q [32];
    logic [WIDTH-1:0] rf_d [32];

    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] rf_wdata;
    logic [4:0]       rf_waddr;
    alu_fn_e          alu_fn;
    logic             pc_en;

    assign imm_sext = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};

    always_comb begin
        alu_a = ALUSrcA ? a_q : pc_q;
        alu_b = b_q;
        case (ALUSrcB)
            2'b00:   alu_b = b_q;
            2'b01:   alu_b = WIDTH'(4);
            2'b10:   alu_b = imm_sext;
            2'b11:   alu_b = {imm_sext[WIDTH-3:0], 2'b00};
            default: alu_b = b_q;
        endcase
    end

    // Unrecognised funct codes produce a zero result rather than an exception.
    always_comb begin
        alu_fn = ALU_ADD;
        case (ALUOp)
            2'b00: alu_fn = ALU_ADD;
            2'b01: alu_fn = ALU_SUB;
            2'b10: begin
                case (ir_q[5:0])
                    6'b100000: alu_fn = ALU_ADD;
                    6'b100010: alu_fn = ALU_SUB;
                    6'b100100: alu_fn = ALU_AND;
                    6'b100101: alu_fn = ALU_OR;
                    6'b101010: alu_fn = ALU_SLT;
                    default:   alu_fn = ALU_NOP;
                endcase
            end
            2'b11: alu_fn = ALU_ADD;
            default: alu_fn = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (alu_fn)
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_SLT: alu_result = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            default: alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

    always_comb begin
        pc_next = pc_q;
        case (PCSource)
            2'b00:   pc_next = alu_result;
            2'b01:   pc_next = aluout_q;
            2'b10:   pc_next = {pc_q[WIDTH-1:WIDTH-4], ir_q[25:0], 2'b00};
            2'b11:   pc_next = pc_q;
            default: pc_next = pc_q;
        endcase
        // PCWrite alone is enough; the conditional path only adds the branch case.
        pc_en = PCWrite | (PCWriteCond & zero);
        pc_d  = pc_en ? pc_next : pc_q;
    end

    always_comb begin
        ir_d     = IRWrite ? mem_rdata : ir_q;
        mdr_d    = mem_rdata;
        a_d      = rf_q[ir_q[25:21]];
        b_d      = rf_q[ir_q[20:16]];
        aluout_d = alu_result;
    end

    always_comb begin
        rf_waddr = RegDst ? ir_q[15:11] : ir_q[20:16];
        rf_wdata = MemtoReg ? mdr_q : aluout_q;
        rf_d     = rf_q;
        if (RegWrite && (rf_waddr != 5'd0)) begin
            rf_d[rf_waddr] = rf_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mdr_q    <= mdr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
            rf_q     <= rf_d;
        end
    end

    assign mem_addr  = IorD ? aluout_q : pc_q;
    assign mem_wdata = b_q;
    assign opcode    = ir_q[31:26];
    assign dbg_pc    = pc_q;

endmodule

// File: doc/mips_mc_datapath.md
Name: mips_mc_datapath

Overview:
- Multicycle MIPS datapath that sits directly downstream of the multicycle controller FSM and consumes all of its control outputs.
- Holds the architectural state: PC, 32x32 register file, and the internal IR, MDR, A, B and ALUOut registers.
- Contains the ALU, the ALU-control decode and all datapath muxes. Returns opcode and zero to the controller.
- Drives a single unified external memory: combinational read, write on the clock edge.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into PC on reset.
- WIDTH, 32, datapath width. Only 32 is supported; it is fixed for readability.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- PCWriteCond, PCWrite, IorD, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA  in  1 each  controller controls.
- PCSource, ALUSrcB, ALUOp  in  2 each  controller controls.
- mem_rdata  in  32  memory read data, combinational from mem_addr.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- opcode  out  6  IR[31:26], to controller.
- zero  out  1  ALU result == 0, combinational.
- dbg_pc  out  32  current PC.

Behaviour:
- Reset (async, rst_n=0):
  - PC = RESET_PC.
  - IR, MDR, A, B, ALUOut = 0.
  - All 32 registers in the register file = 0.
  - Resulting outputs: mem_addr = RESET_PC, opcode = 0, mem_wdata = 0.
  - Mid-operation assertion clears state immediately. First rising edge after release performs normal updates.
- Memory interface:
  - mem_addr = IorD ? ALUOut : PC.
  - mem_wdata = B.
- IR: loads mem_rdata on an edge with IRWrite=1, otherwise holds.
- Per-edge loads: MDR loads mem_rdata on every edge.
- Register reads:
  - A loads regfile[IR[25:21]] on every edge.
  - B loads regfile[IR[20:16]] on every edge.
  - Reads use pre-edge contents, so a same-edge write is not visible until the next cycle.
- ALUOut: loads the ALU result on every edge.
- ALU operand A: ALUSrcA ? A : PC.
- ALU operand B:
  - 00: B.
  - 01: 32'd4.
  - 10: sign-extended IR[15:0].
  - 11: sign-extended IR[15:0] << 2.
- ALU control:
  - ALUOp 00: add.
  - ALUOp 01: sub.
  - ALUOp 10: decode IR[5:0]:
    - 100000 add, 100010 sub, 100100 and, 100101 or.
    - 101010 slt: signed compare, result 32'd1 or 32'd0.
    - Any other funct: result 0.
  - ALUOp 11: add.
  - All arithmetic wraps modulo 2^32. There are no overflow exceptions.
- PC next value by PCSource:
  - 00: ALU result (combinational).
  - 01: ALUOut.
  - 10: {PC[31:28], IR[25:0], 2'b00}.
  - 11: PC, i.e. hold.
- PC enable: PC loads when PCWrite | (PCWriteCond & zero).
  - PCWrite and PCWriteCond both 1: PCWrite dominates and PC loads unconditionally.
- Register file write, on an edge with RegWrite=1:
  - Destination = RegDst ? IR[15:11] : IR[20:16].
  - Data = MemtoReg ? MDR : ALUOut.
  - Writes to register 0 are discarded; register 0 always reads 0.
- No FSM is internal to this block. Sequencing is owned by the controller; this block only reacts to the controls present at each edge.

Test Plan:
- Reset: hold rst_n=0, then release → dbg_pc=RESET_PC, mem_addr=RESET_PC, opcode=0. Any register read returns 0.
- Fetch step, PC=0, mem_rdata=32'h8C22_0004 (lw $2,4($1)): drive IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00 for one edge → IR=32'h8C22_0004, PC=4, opcode=6'b100011.
- R-type add, $1=5, $2=7, IR=32'h0022_1820 (add $3,$1,$2): sequence decode→exec→rcomp controls → ALUOut=12, $3=12. A write with dest $0 leaves $0=0.
- BEQ taken/not-taken, PC=8, imm=3, $1=$2=9: EXEC-style sub with PCWriteCond=1, PCSource=01, ALUOut=8+12 → PC=20. Repeat with $2=10 → PC stays 8.
- Jump, PC=32'h4000_0010, IR=32'h0800_0040: PCWrite=1, PCSource=10 → PC=32'h4000_0100.
- Async reset mid-instruction: assert rst_n between edges while IorD=1 → mem_addr=RESET_PC in the same cycle, and IR/A/B/ALUOut=0.
